seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Downstream display stage of the processor top: consumes a 16-bit value (typically a result register or PC) plus per-digit decimal points.
- Time-multiplexes the value as four hex digits onto the board's common-anode 4-digit seven-segment display via the anode/catode pins.
- Uses a valid/ready load handshake with frame-boundary double buffering so a digit frame never shows a torn value.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (>=1); 1 = advance every cycle (simulation).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
load_valid  input  1  producer offers load_data/load_dp this cycle
load_ready  output  1  driver can accept a load (pending buffer empty)
load_data  input  16  value to display; nibble k -> digit k, digit 0 rightmost
load_dp  input  4  decimal point per digit, 1 = lit
blank_lz  input  1  1 = blank leading-zero digits (static config)
anode  output  4  digit enables, active-low, anode[k] = digit k
catode  output  8  active-low segments, [7]=dp, [6:0]={g,f,e,d,c,b,a}
frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (reset=0, async):
  - prescaler=0, digit index=0, shown value/dp=0, pending empty.
  - anode=4'b1111, catode=8'hFF, frame_tick=0, load_ready=1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1; tick asserted when count==REFRESH_DIV-1, count then wraps to 0.
- Scan: on each tick, digit index advances 0->1->2->3->0.
  - anode and catode are registered and updated on the tick edge for the new index.
  - Between reset release and the first tick all digits stay dark.
  - First lit digit after reset is digit 1 (index advances from 0).
- Frame boundary = tick on which index wraps 3->0.
  - frame_tick=1 for exactly that cycle.
  - If pending full: shown <= pending, pending empties in the same edge.
  - Digit 0 of the new frame is rendered from the newly transferred value.
- Handshake:
  - load_ready = ~pending_full (combinational from register).
  - Transfer occurs when load_valid && load_ready; pending captures data and dp, pending_full=1.
  - While full, load_ready=0; load_valid ignored; producer must hold its request.
  - Accept on the same cycle as a frame boundary with pending empty: data captured, displayed at the next boundary, not the current one.
  - No bypass: a new value never reaches the display before a boundary.
- Segment encoding, active-low [6:0], by hex value:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
  - catode[7] = ~dp of the shown digit.
- Leading-zero blanking:
  - Applies when blank_lz=1: digit k (k=1..3) is blank if shown nibbles k..3 are all zero.
  - Blank digit: catode[6:0]=7'h7F; dp still follows dp bit; anode still scans.
  - Digit 0 is never blanked; value 0 shows a single "0".
  - blank_lz is evaluated at each tick.
- Reset mid-frame:
  - Immediate return to reset state; pending load discarded; display dark until next tick.

Test Plan:
- REFRESH_DIV=4, reset low 3 cycles then high -> anode=4'b1111, catode=8'hFF until cycle 4 after release; then anode 1101,1011,0111,1110 every 4 cycles; frame_tick pulses every 16 cycles.
- Load 16'h1A2F, dp=0, blank_lz=0 -> after the next boundary, digits 0..3 catode = 8'h8E, 8'hA4, 8'h88, 8'hF9; load_ready high again on the cycle after the transfer edge.
- Two back-to-back loads (16'h1234, then 16'h5678 held valid) -> second load stalls with load_ready=0 until the boundary; 1234 is shown for one full frame, then 5678.
- Load 16'h0007 with blank_lz=1, dp=4'b0100 -> digit0 catode=8'hF8, digit1 catode=8'hFF, digit2 catode=8'h7F (dp only), digit3 catode=8'hFF.
- Load accepted on the boundary cycle -> current frame keeps the old value; new value appears at the following boundary.
- Assert reset mid-frame with pending full -> outputs dark immediately, load_ready=1; after release the shown value is 0000, rendered as "0000", or "0" when blank_lz=1.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Load handshake between the value producer and the
// seven-segment scan driver.
interface seg7_scan_driver_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode hex display scanner with a
// one-entry pending buffer swapped in at frame boundaries.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_driver_if.slave   ld,
  input  logic                blank_lz,
  output logic [3:0]          anode,
  output logic [7:0]          catode,
  output logic                frame_tick
);

  localparam int PW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shown_q, shown_d;
  logic [3:0]    sdp_q, sdp_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    pdp_q, pdp_d;
  logic          full_q, full_d;
  logic [3:0]    anode_q, anode_d;
  logic [7:0]    catode_q, catode_d;
  logic          tick, wrap, xfer, accept;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] render(
    input logic [15:0] v,
    input logic [3:0]  dp,
    input logic [1:0]  k,
    input logic        blz
  );
    logic       zhi;
    logic [3:0] nib;
    nib = v[{k, 2'b00} +: 4];
    unique case (k)
      2'd0: zhi = 1'b0;
      2'd1: zhi = (v[15:4] == 12'h000);
      2'd2: zhi = (v[15:8] == 8'h00);
      2'd3: zhi = (v[15:12] == 4'h0);
    endcase
    return {~dp[k], (blz && zhi) ? 7'h7F : seg(nib)};
  endfunction

  always_comb begin
    tick   = (presc_q == LAST);
    wrap   = tick && (idx_q == 2'd3);
    xfer   = wrap && full_q;
    accept = ld.load_valid && !full_q;

    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = tick ? idx_q + 2'd1 : idx_q;
    shown_d  = xfer ? pend_q : shown_q;
    sdp_d    = xfer ? pdp_q : sdp_q;
    pend_d   = accept ? ld.load_data : pend_q;
    pdp_d    = accept ? ld.load_dp : pdp_q;
    full_d   = accept ? 1'b1 : (xfer ? 1'b0 : full_q);
    anode_d  = anode_q;
    catode_d = catode_q;

    // Render from the post-swap value so digit 0 of a
    // new frame already shows the transferred data.
    if (tick) begin
      anode_d  = ~(4'b0001 << idx_d);
      catode_d = render(shown_d, sdp_d, idx_d, blank_lz);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      idx_q    <= 2'd0;
      shown_q  <= 16'h0000;
      sdp_q    <= 4'h0;
      pend_q   <= 16'h0000;
      pdp_q    <= 4'h0;
      full_q   <= 1'b0;
      anode_q  <= 4'hF;
      catode_q <= 8'hFF;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      shown_q  <= shown_d;
      sdp_q    <= sdp_d;
      pend_q   <= pend_d;
      pdp_q    <= pdp_d;
      full_q   <= full_d;
      anode_q  <= anode_d;
      catode_q <= catode_d;
    end
  end

  assign ld.load_ready = ~full_q;
  assign anode         = anode_q;
  assign catode        = catode_q;
  assign frame_tick    = wrap;

endmodule
